// File: rtl/oisc8_mov_seq.sv
// ---------------------------------------------------------------------------
// oisc8_mov_seq
//
// Move sequencer of the oisc8 core. Sits between the PC/ROM fetch stage and
// the bus ports. Each accepted 16-bit word is one move:
//   instr[15]    imm flag (1: instr[7:0] is the value to write)
//   instr[14:8]  destination port address (0 means NOP)
//   instr[7:0]   source port address, or the immediate value
// A register move reads the source port first and then writes the
// destination port. An immediate move writes straight away. A completed
// write to the PC port is followed by a one-cycle FLUSH that swallows the
// word fetched before the PC changed.
//
// Handshakes:
//   instr_valid/instr_ready : a word transfers on a cycle where both are 1.
//                             instr must be held stable while valid && !ready.
//   src_rd/src_ack          : src_rd stays high until the cycle src_ack is 1.
//                             src_data is sampled in that cycle.
//   dst_wr/dst_ack          : dst_wr stays high until the cycle dst_ack is 1.
//                             dst_addr and dst_data do not change meanwhile.
//   An ack that does not come within MAX_WAIT strobe cycles aborts the
//   move and sets the sticky timeout_err.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   instr           instruction word from fetch
//   instr_valid     instr holds a fetched word
//   instr_ready     word accepted this cycle (combinational)
//   src_addr/src_rd source read address and strobe (registered)
//   src_data/src_ack source read data and completion
//   dst_addr/dst_data/dst_wr destination write address, data, strobe
//   dst_ack         destination write completion
//   flush           one-cycle pulse after a completed PC write
//   busy            sequencer is not idle
//   timeout_err     sticky abort flag, cleared only by rst
// ---------------------------------------------------------------------------
module oisc8_mov_seq #(
    parameter int               DSIZE    = 8,
    parameter int               ASIZE    = 7,
    parameter logic [ASIZE-1:0] PC_ADDR  = 7'h01,
    parameter int               MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [7:0]       src_addr,
    output logic             src_rd,
    input  logic [DSIZE-1:0] src_data,
    input  logic             src_ack,
    output logic [ASIZE-1:0] dst_addr,
    output logic [DSIZE-1:0] dst_data,
    output logic             dst_wr,
    input  logic             dst_ack,
    output logic             flush,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    // The counter holds the number of strobe cycles already spent without
    // an ack, so the cycle in which it equals MAX_WAIT-1 is the last one an
    // ack may still arrive in.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t           state_q,       state_d;
    logic [7:0]       wait_q,        wait_d;
    logic             timeout_err_q, timeout_err_d;
    logic [7:0]       src_addr_q,    src_addr_d;
    logic             src_rd_q,      src_rd_d;
    logic [ASIZE-1:0] dst_addr_q,    dst_addr_d;
    logic [DSIZE-1:0] dst_data_q,    dst_data_d;
    logic             dst_wr_q,      dst_wr_d;
    logic             flush_q,       flush_d;

    // -----------------------------------------------------------------------
    // Instruction decode and shared conditions
    // -----------------------------------------------------------------------
    logic             instr_imm;
    logic             instr_nop;
    logic [ASIZE-1:0] instr_dst;
    state_t           decode_target;
    logic             pc_hit;
    logic             wait_hit;
    logic             decode_go;
    logic             start_read;
    logic             start_imm;
    logic             read_done;

    assign instr_imm = instr[15];
    assign instr_nop = (instr[14:8] == 7'd0);
    assign instr_dst = ASIZE'(instr[14:8]);

    // Where a freshly decoded word sends the sequencer.
    assign decode_target = instr_nop ? S_IDLE : (instr_imm ? S_WRITE : S_READ);

    // The destination of the write in flight is the PC port.
    assign pc_hit   = (dst_addr_q == PC_ADDR);
    assign wait_hit = (wait_q == WAIT_LAST);

    // A new word is decoded in IDLE, or in the last cycle of a non-PC write
    // so that immediate moves can retire one per cycle. Words taken in
    // FLUSH are discarded and never reach this decode.
    assign decode_go  = instr_valid &&
                        ((state_q == S_IDLE) ||
                         ((state_q == S_WRITE) && dst_ack && !pc_hit));
    assign start_read = decode_go && !instr_nop && !instr_imm;
    assign start_imm  = decode_go && !instr_nop &&  instr_imm;
    assign read_done  = (state_q == S_READ) && src_ack;

    // -----------------------------------------------------------------------
    // Process 1: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wait_q        <= '0;
            timeout_err_q <= 1'b0;
            src_addr_q    <= '0;
            src_rd_q      <= 1'b0;
            dst_addr_q    <= '0;
            dst_data_q    <= '0;
            dst_wr_q      <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            timeout_err_q <= timeout_err_d;
            src_addr_q    <= src_addr_d;
            src_rd_q      <= src_rd_d;
            dst_addr_q    <= dst_addr_d;
            dst_data_q    <= dst_data_d;
            dst_wr_q      <= dst_wr_d;
            flush_q       <= flush_d;
        end
    end

    // -----------------------------------------------------------------------
    // Process 2: next state, wait counter, sticky error
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        wait_d        = '0;
        timeout_err_d = timeout_err_q;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    state_d = decode_target;
                end
            end

            S_READ: begin
                if (src_ack) begin
                    state_d = S_WRITE;
                end else if (wait_hit) begin
                    // Read abandoned: nothing is written.
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_WRITE: begin
                if (dst_ack) begin
                    if (pc_hit) begin
                        state_d = S_FLUSH;
                    end else if (instr_valid) begin
                        state_d = decode_target;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (wait_hit) begin
                    // Write abandoned: an aborted PC write does not flush.
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_FLUSH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every entry into a strobe phase starts a fresh wait budget.
        if (start_read || start_imm || read_done) begin
            wait_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Process 3: outputs (instr_ready directly, the rest via registers)
    // -----------------------------------------------------------------------
    always_comb begin
        instr_ready = 1'b0;
        src_addr_d  = src_addr_q;
        dst_addr_d  = dst_addr_q;
        dst_data_d  = dst_data_q;

        case (state_q)
            S_IDLE:  instr_ready = 1'b1;
            S_READ:  instr_ready = 1'b0;
            S_WRITE: instr_ready = dst_ack && !pc_hit;
            S_FLUSH: instr_ready = 1'b1;
            default: instr_ready = 1'b0;
        endcase

        // Strobes and the flush pulse simply mirror the state being entered.
        src_rd_d = (state_d == S_READ);
        dst_wr_d = (state_d == S_WRITE);
        flush_d  = (state_d == S_FLUSH);

        // Addresses and data only change when a new phase is loaded, which
        // keeps them stable for the whole strobe.
        if (start_read) begin
            src_addr_d = instr[7:0];
            dst_addr_d = instr_dst;
        end
        if (start_imm) begin
            dst_addr_d = instr_dst;
            dst_data_d = DSIZE'(instr[7:0]);
        end
        if (read_done) begin
            dst_data_d = src_data;
        end
    end

    assign src_addr    = src_addr_q;
    assign src_rd      = src_rd_q;
    assign dst_addr    = dst_addr_q;
    assign dst_data    = dst_data_q;
    assign dst_wr      = dst_wr_q;
    assign flush       = flush_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_oisc8_mov_seq.sv
// ---------------------------------------------------------------------------
// Testbench for oisc8_mov_seq: directed scenarios followed by a randomized
// instruction stream checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_oisc8_mov_seq;

    localparam int         MAX_WAIT = 15;
    localparam logic [6:0] PC_ADDR  = 7'h01;
    localparam int         N_RND    = 80;
    localparam int         BUDGET   = 6000;

    // -----------------------------------------------------------------------
    // Clock / reset / DUT
    // -----------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  src_addr;
    logic        src_rd;
    logic [7:0]  src_data;
    logic        src_ack;
    logic [6:0]  dst_addr;
    logic [7:0]  dst_data;
    logic        dst_wr;
    logic        dst_ack;
    logic        flush;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    oisc8_mov_seq #(
        .DSIZE    (8),
        .ASIZE    (7),
        .PC_ADDR  (PC_ADDR),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .src_addr    (src_addr),
        .src_rd      (src_rd),
        .src_data    (src_data),
        .src_ack     (src_ack),
        .dst_addr    (dst_addr),
        .dst_data    (dst_data),
        .dst_wr      (dst_wr),
        .dst_ack     (dst_ack),
        .flush       (flush),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Scoreboard for the random phase
    // -----------------------------------------------------------------------
    logic [14:0] exp_q[$];     // {dst_addr, dst_data} of expected writes
    logic [7:0]  rd_exp_q[$];  // expected source addresses of completed reads

    logic [15:0] w_word     [N_RND];
    int          w_rd_delay [N_RND];
    int          w_wr_delay [N_RND];
    logic [7:0]  w_rd_data  [N_RND];
    bit          w_discard  [N_RND];

    int  exp_flush;
    int  exp_writes;
    int  exp_reads;
    bit  exp_err;

    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0)      return MAX_WAIT + $urandom_range(1, 3);
        else if (r == 1) return MAX_WAIT;
        else             return $urandom_range(1, 5);
    endfunction

    // Reference model: walk the word list in program order applying the
    // architectural rules (NOP, read, write, timeouts, PC flush).
    task automatic build_stream();
        logic [6:0] g_dst;
        logic [7:0] g_val;
        logic [7:0] data;
        bit         imm;
        bit         discard_next;
        int         r;
        exp_q.delete();
        rd_exp_q.delete();
        exp_flush    = 0;
        exp_writes   = 0;
        exp_reads    = 0;
        exp_err      = 1'b0;
        discard_next = 1'b0;
        for (int i = 0; i < N_RND; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      g_dst = 7'h00;
            else if (r == 1) g_dst = PC_ADDR;
            else             g_dst = 7'($urandom_range(2, 127));
            imm   = 1'($urandom_range(0, 1));
            g_val = 8'($urandom);
            w_word[i]     = {imm, g_dst, g_val};
            w_rd_data[i]  = 8'($urandom);
            w_rd_delay[i] = pick_delay();
            w_wr_delay[i] = pick_delay();
            w_discard[i]  = discard_next;
            if (discard_next) begin
                discard_next = 1'b0;
            end else if (g_dst != 7'h00) begin
                if (!imm && w_rd_delay[i] > MAX_WAIT) begin
                    exp_err = 1'b1;
                end else begin
                    if (!imm) begin
                        rd_exp_q.push_back(g_val);
                        exp_reads++;
                        data = w_rd_data[i];
                    end else begin
                        data = g_val;
                    end
                    if (w_wr_delay[i] > MAX_WAIT) begin
                        exp_err = 1'b1;
                    end else begin
                        exp_q.push_back({g_dst, data});
                        exp_writes++;
                        if (g_dst == PC_ADDR) begin
                            exp_flush++;
                            discard_next = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    logic [15:0] imm_tab [3];
    logic [15:0] w;

    initial begin
        int idx, cur, gap_left, rd_cnt, wr_cnt, cyc;
        int wr_seen, rd_seen, flush_seen;
        bit have_cur;
        logic [14:0] e_wr;
        logic [7:0]  e_rd;

        rst = 1'b1; instr = '0; instr_valid = 1'b0;
        src_data = '0; src_ack = 1'b0; dst_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // ---- reset state
        check_val("rst_ready", instr_ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_src_rd", src_rd, 0);
        check_val("rst_dst_wr", dst_wr, 0);
        check_val("rst_flush", flush, 0);
        check_val("rst_terr", timeout_err, 0);
        check_val("rst_dst_addr", dst_addr, 0);
        check_val("rst_dst_data", dst_data, 0);
        check_val("rst_src_addr", src_addr, 0);

        // ---- back-to-back immediates with dst_ack tied high
        imm_tab[0] = 16'h8A5C;
        imm_tab[1] = 16'h8B21;
        imm_tab[2] = 16'h8C93;
        dst_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w = imm_tab[k];
            instr = w; instr_valid = 1'b1;
            #1;
            check_val("imm_ready", instr_ready, 1);
            tick();
            check_val("imm_dst_wr", dst_wr, 1);
            check_val("imm_dst_addr", dst_addr, 32'(w[14:8]));
            check_val("imm_dst_data", dst_data, 32'(w[7:0]));
        end
        instr_valid = 1'b0;
        #1;
        tick();
        check_val("imm_idle_wr", dst_wr, 0);
        check_val("imm_idle_busy", busy, 0);

        // ---- register move, src_ack on the third read cycle
        instr = 16'h0B20; instr_valid = 1'b1;
        #1;
        tick();
        instr_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check_val("reg_src_rd", src_rd, 1);
            check_val("reg_src_addr", src_addr, 32'h20);
            check_val("reg_no_wr", dst_wr, 0);
            src_ack  = (c == 3);
            src_data = (c == 3) ? 8'h7E : 8'h00;
            #1;
            check_val("reg_ready_low", instr_ready, 0);
            tick();
        end
        src_ack = 1'b0;
        check_val("reg_rd_drop", src_rd, 0);
        check_val("reg_dst_wr", dst_wr, 1);
        check_val("reg_dst_addr", dst_addr, 32'h0B);
        check_val("reg_dst_data", dst_data, 32'h7E);
        #1;
        tick();
        check_val("reg_done_busy", busy, 0);

        // ---- immediate write to PC, flush and discard
        instr = 16'h8140; instr_valid = 1'b1;
        #1;
        tick();
        check_val("pc_dst_wr", dst_wr, 1);
        check_val("pc_dst_addr", dst_addr, 32'h01);
        instr = 16'h8A77;
        #1;
        check_val("pc_ready_low", instr_ready, 0);
        tick();
        check_val("pc_flush", flush, 1);
        check_val("pc_flush_no_wr", dst_wr, 0);
        #1;
        check_val("pc_flush_ready", instr_ready, 1);
        tick();
        check_val("pc_flush_drop", flush, 0);
        check_val("pc_discard_wr", dst_wr, 0);
        check_val("pc_discard_rd", src_rd, 0);
        check_val("pc_discard_busy", busy, 0);
        instr = 16'h8C99;
        #1;
        check_val("pc_next_ready", instr_ready, 1);
        tick();
        check_val("pc_next_wr", dst_wr, 1);
        check_val("pc_next_addr", dst_addr, 32'h0C);
        check_val("pc_next_data", dst_data, 32'h99);
        instr_valid = 1'b0;
        #1;
        tick();

        // ---- NOP
        instr = 16'h0033; instr_valid = 1'b1;
        #1;
        check_val("nop_ready", instr_ready, 1);
        tick();
        check_val("nop_busy", busy, 0);
        check_val("nop_src_rd", src_rd, 0);
        check_val("nop_dst_wr", dst_wr, 0);
        instr = 16'h8D12;
        #1;
        check_val("nop_next_ready", instr_ready, 1);
        tick();
        check_val("nop_next_wr", dst_wr, 1);
        check_val("nop_next_data", dst_data, 32'h12);
        instr_valid = 1'b0;
        #1;
        tick();

        // ---- write timeout, then sticky error over a good move
        dst_ack = 1'b0;
        instr = 16'h8E44; instr_valid = 1'b1;
        #1;
        tick();
        instr_valid = 1'b0;
        for (int c = 1; c <= MAX_WAIT; c++) begin
            check_val("wto_wr_held", dst_wr, 1);
            check_val("wto_no_err_yet", timeout_err, 0);
            tick();
        end
        check_val("wto_wr_drop", dst_wr, 0);
        check_val("wto_err", timeout_err, 1);
        check_val("wto_busy", busy, 0);
        dst_ack = 1'b1;
        instr = 16'h8F55; instr_valid = 1'b1;
        #1;
        tick();
        check_val("wto_good_wr", dst_wr, 1);
        check_val("wto_good_data", dst_data, 32'h55);
        instr_valid = 1'b0;
        #1;
        tick();
        check_val("wto_sticky", timeout_err, 1);

        // ---- read timeout produces no write
        src_ack = 1'b0;
        instr = 16'h0B20; instr_valid = 1'b1;
        #1;
        tick();
        instr_valid = 1'b0;
        for (int c = 1; c <= MAX_WAIT; c++) begin
            check_val("rto_rd_held", src_rd, 1);
            tick();
        end
        check_val("rto_rd_drop", src_rd, 0);
        check_val("rto_no_wr", dst_wr, 0);
        check_val("rto_busy", busy, 0);
        tick();
        check_val("rto_no_wr_later", dst_wr, 0);

        // ---- reset while a read waits; late ack ignored
        instr = 16'h0B21; instr_valid = 1'b1;
        #1;
        tick();
        instr_valid = 1'b0;
        tick();
        check_val("mrst_rd_before", src_rd, 1);
        rst = 1'b1;
        #1;
        tick();
        check_val("mrst_src_rd", src_rd, 0);
        check_val("mrst_busy", busy, 0);
        check_val("mrst_terr", timeout_err, 0);
        rst = 1'b0; src_ack = 1'b1; src_data = 8'hAA;
        #1;
        check_val("mrst_ready", instr_ready, 1);
        tick();
        check_val("mrst_late_rd", src_rd, 0);
        check_val("mrst_late_wr", dst_wr, 0);
        check_val("mrst_late_busy", busy, 0);
        src_ack = 1'b0;

        // ---- ack in the last allowed cycle wins
        dst_ack = 1'b0;
        instr = 16'h8E66; instr_valid = 1'b1;
        #1;
        tick();
        instr_valid = 1'b0;
        for (int c = 1; c <= MAX_WAIT; c++) begin
            check_val("late_ack_wr_held", dst_wr, 1);
            dst_ack = (c == MAX_WAIT);
            #1;
            if (c == MAX_WAIT) check_val("late_ack_ready", instr_ready, 1);
            tick();
        end
        dst_ack = 1'b0;
        check_val("late_ack_wr_drop", dst_wr, 0);
        check_val("late_ack_no_err", timeout_err, 0);
        check_val("late_ack_busy", busy, 0);

        // ---- randomized stream
        rst = 1'b1;
        tick();
        rst = 1'b0;
        build_stream();
        idx = 0; cur = 0; have_cur = 1'b0; gap_left = 0;
        rd_cnt = 0; wr_cnt = 0; cyc = 0;
        wr_seen = 0; rd_seen = 0; flush_seen = 0;
        while ((idx < N_RND || busy) && cyc < BUDGET) begin
            rd_cnt  = src_rd ? rd_cnt + 1 : 0;
            wr_cnt  = dst_wr ? wr_cnt + 1 : 0;
            src_ack = have_cur && src_rd && (rd_cnt == w_rd_delay[cur]);
            src_data = src_ack ? w_rd_data[cur] : 8'($urandom);
            dst_ack = have_cur && dst_wr && (wr_cnt == w_wr_delay[cur]);
            if (idx < N_RND && gap_left == 0) begin
                instr_valid = 1'b1;
                instr       = w_word[idx];
            end else begin
                instr_valid = 1'b0;
                instr       = 16'($urandom);
            end
            #1;
            if (src_rd && src_ack) begin
                rd_seen++;
                if (rd_exp_q.size() > 0) begin
                    e_rd = rd_exp_q.pop_front();
                    check_val("rnd_src_addr", src_addr, e_rd);
                end
            end
            if (dst_wr && dst_ack) begin
                wr_seen++;
                if (exp_q.size() > 0) begin
                    e_wr = exp_q.pop_front();
                    check_val("rnd_write", {dst_addr, dst_data}, e_wr);
                end
            end
            if (flush) flush_seen++;
            if (instr_valid && instr_ready) begin
                if (!w_discard[idx]) begin
                    cur      = idx;
                    have_cur = 1'b1;
                end
                idx++;
                gap_left = (idx < N_RND && !w_discard[idx]) ? $urandom_range(0, 2) : 0;
            end else if (!instr_valid && gap_left > 0) begin
                gap_left--;
            end
            if (dst_ack) wr_cnt = 0;
            if (src_ack) rd_cnt = 0;
            tick();
            cyc++;
        end
        src_ack = 1'b0; dst_ack = 1'b0; instr_valid = 1'b0;
        check_val("rnd_budget", (cyc < BUDGET), 1);
        check_val("rnd_write_cnt", wr_seen, exp_writes);
        check_val("rnd_read_cnt", rd_seen, exp_reads);
        check_val("rnd_flush_cnt", flush_seen, exp_flush);
        check_val("rnd_terr", timeout_err, exp_err);
        tick();
        check_val("rnd_end_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/oisc8_mov_seq.md
Name: oisc8_mov_seq

Overview:
- Move sequencer for the oisc8 core, directly downstream of the program-counter/ROM fetch stage and upstream of the bus ports (ACC, ADD, SUB, ...).
- Accepts one 16-bit move instruction per handshake, reads the source port or takes an immediate, then writes the destination port.
- Stalls fetch while a port is slow to acknowledge.
- Detects writes to the PC port and flushes the one stale fetched instruction.

Parameters:
- DSIZE, 8, data bus width.
- ASIZE, 7, destination address width.
- PC_ADDR, 7'h01, destination address of the PC port; a completed write here triggers a flush.
- MAX_WAIT, 15, cycles a READ/WRITE waits for ack before abort; range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- instr  in  16  instruction word: [15] imm flag, [14:8] dst addr, [7:0] src addr or immediate.
- instr_valid  in  1  instr holds a fetched word.
- instr_ready  out  1  word accepted this cycle; PC advances only on valid&&ready.
- src_addr  out  8  source port address.
- src_rd  out  1  source read strobe, held until ack.
- src_data  in  DSIZE  source read data, sampled on src_ack.
- src_ack  in  1  source read complete.
- dst_addr  out  ASIZE  destination port address.
- dst_data  out  DSIZE  destination write data.
- dst_wr  out  1  destination write strobe, held until ack.
- dst_ack  in  1  destination write complete.
- flush  out  1  one-cycle pulse after a completed PC write.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky abort flag; cleared only by rst.

Behaviour:
- Reset (clk edge with rst=1): state IDLE; all outputs 0 except instr_ready; wait counter 0; timeout_err 0. instr_ready is combinational and is 1 in IDLE, so it reads 1 after reset.
- Reset mid-transaction abandons the transaction; strobes are 0 from the next edge onward.
- All strobe, address and data outputs are registered. instr_ready is combinational from state and acks.
- IDLE: instr_ready=1. On instr_valid:
  - dst==0 (NOP): retire immediately, remain in IDLE.
  - imm=1: load dst_data=instr[7:0], go to WRITE.
  - otherwise: load src_addr=instr[7:0], go to READ.
- READ: src_rd=1, instr_ready=0.
  - On src_ack: latch src_data into dst_data, drop src_rd, go to WRITE.
  - src_ack is ignored in every other state.
- WRITE: dst_wr=1.
  - On dst_ack with dst!=PC_ADDR: instr_ready=1 in that same cycle. A new instruction presented then is decoded as in IDLE, giving back-to-back throughput of 1 immediate move per cycle. Without a new instruction, go to IDLE.
  - On dst_ack with dst==PC_ADDR: instr_ready=0, flush=1 on the next cycle, go to FLUSH.
- FLUSH (one cycle): instr_ready=1. Any valid instr is consumed and discarded (the ROM word fetched before the PC write). Go to IDLE.
- Latency:
  - Immediate move: accept at cycle N, dst_wr high at N+1.
  - Register move: src_rd at N+1, dst_wr the cycle after src_ack.
- Timeout:
  - Wait counter clears on entry to READ/WRITE and increments each cycle without ack.
  - When it reaches MAX_WAIT with no ack: drop the strobe, set timeout_err, go to IDLE, no write.
  - A read timeout produces no write.
  - An ack arriving in the same cycle the counter reaches MAX_WAIT wins; no error is raised.
- Timeout on a PC write produces no flush.
- dst_addr and dst_data stay stable throughout WRITE. src_addr stays stable throughout READ.

Test Plan:
- Reset, then instr=16'h8A5C (imm, dst 0x0A, val 0x5C) with dst_ack tied 1 -> dst_wr=1, dst_addr=0x0A, dst_data=0x5C one cycle after accept. Three back-to-back immediates retire in 3 consecutive cycles.
- Register move instr=16'h0B20 (dst 0x0B, src 0x20); src_ack after 3 cycles with src_data=0x7E -> src_rd held 3 cycles, instr_ready=0 throughout, then dst_wr with data 0x7E.
- Immediate write to PC (instr=16'h8140) acked -> flush pulses 1 cycle; next valid word accepted and discarded (no strobe); following word executes normally.
- dst_ack withheld with MAX_WAIT=15 -> dst_wr drops after 15 cycles, timeout_err=1 and stays 1 over later good moves; ack on cycle 15 exactly -> no error.
- NOP instr=16'h0033 -> no src_rd/dst_wr, busy stays 0, next instruction accepted the following cycle.
- rst asserted while src_rd waiting -> src_rd=0, busy=0, timeout_err=0 after the edge; late src_ack ignored.
